time_unit_counter: RTL

TIME_UNIT_COUNTER -- requirements
Module: time_unit_counter

---
 rtl/time_unit_counter.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/time_unit_counter.sv
// ---------------------------------------------------------------------------
// time_unit_counter
//
// One digit-pair of a settable clock (seconds, minutes or hours). In run mode
// the value advances on a one-second tick, taken either from an internal
// prescaler or from the carry strobe of the next-lower unit. In set mode the
// value is stepped up or down by two push-buttons, with auto-repeat while a
// button is held.
//
// Ports
//   clk_50     : single clock, all logic on its rising edge
//   rst_n      : asynchronous active-low reset
//   mode       : 0 = run, 1 = set
//   select     : 1 = this unit is the one being edited in set mode
//   key_inc_n  : raw active-low increment button (asynchronous)
//   key_dec_n  : raw active-low decrement button (asynchronous)
//   tick_in    : one-cycle advance strobe, used when USE_EXT_TICK = 1
//   count      : registered current value, always 0..MODULO-1
//   bcd_tens   : count / 10
//   bcd_ones   : count % 10
//   carry_out  : registered one-cycle strobe when the count wraps to 0
//
// Parameters
//   CLK_HZ       : clock cycles per internal tick
//   MODULO       : count range 0..MODULO-1, legal 2..100
//   WIDTH        : count width, 2**WIDTH >= MODULO
//   USE_EXT_TICK : 0 = internal prescaler, 1 = tick_in
//   REPEAT_DLY   : held-key cycles before auto-repeat starts
//   REPEAT_PER   : cycles between auto-repeat steps
// ---------------------------------------------------------------------------
module time_unit_counter #(
  parameter int CLK_HZ       = 50_000_000,
  parameter int MODULO       = 60,
  parameter int WIDTH        = 7,
  parameter int USE_EXT_TICK = 0,
  parameter int REPEAT_DLY   = 25_000_000,
  parameter int REPEAT_PER   = 10_000_000
) (
  input  logic             clk_50,
  input  logic             rst_n,
  input  logic             mode,
  input  logic             select,
  input  logic             key_inc_n,
  input  logic             key_dec_n,
  input  logic             tick_in,
  output logic [WIDTH-1:0] count,
  output logic [3:0]       bcd_tens,
  output logic [3:0]       bcd_ones,
  output logic             carry_out
);

  localparam int PW   = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int RMAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
  localparam int RW   = (RMAX > 0) ? $clog2(RMAX + 1) : 1;

  localparam logic [PW-1:0]    PRESC_LAST = PW'(CLK_HZ - 1);
  localparam logic [RW-1:0]    DLY_CYC    = RW'(REPEAT_DLY);
  localparam logic [RW-1:0]    PER_CYC    = RW'(REPEAT_PER);
  localparam logic [WIDTH-1:0] CNT_MAX    = WIDTH'(MODULO - 1);

  // Index 0 is the increment key, index 1 the decrement key.
  localparam int KEY_INC = 0;
  localparam int KEY_DEC = 1;

  // -------------------------------------------------------------------------
  // Helper functions: wrap-around stepping and BCD split
  // -------------------------------------------------------------------------
  function automatic logic [WIDTH-1:0] step_up(input logic [WIDTH-1:0] v);
    return (v == CNT_MAX) ? '0 : v + 1'b1;
  endfunction

  function automatic logic [WIDTH-1:0] step_down(input logic [WIDTH-1:0] v);
    return (v == '0) ? CNT_MAX : v - 1'b1;
  endfunction

  function automatic logic [3:0] to_tens(input logic [WIDTH-1:0] v);
    logic [7:0] v8;
    v8 = 8'(v);
    return 4'(v8 / 8'd10);
  endfunction

  function automatic logic [3:0] to_ones(input logic [WIDTH-1:0] v);
    logic [7:0] v8;
    v8 = 8'(v);
    return 4'(v8 % 8'd10);
  endfunction

  // -------------------------------------------------------------------------
  // Declarations
  // -------------------------------------------------------------------------
  logic [1:0]    key_raw;
  logic [1:0]    key_p0;     // first synchroniser stage
  logic [1:0]    key_p1;     // synchronised key level (0 = pressed)
  logic [1:0]    key_p2;     // previous synchronised level, for edge detect

  logic [1:0]    press;      // 1->0 transition of the synchronised level
  logic [1:0]    held;
  logic [1:0]    rep_fire;
  logic [1:0]    step;
  logic          edit;

  logic [RW-1:0] rep_cnt [2];
  logic [1:0]    rep_on;     // 0 = waiting for initial delay, 1 = repeating

  logic [PW-1:0] presc;
  logic          int_tick;
  logic          adv;

  // Blocks any step or carry on the first clock after reset release.
  logic          armed;

  logic [WIDTH-1:0] count_nxt;
  logic             carry_nxt;

  assign key_raw = {key_dec_n, key_inc_n};

  // -------------------------------------------------------------------------
  // Stage p0/p1/p2: key synchroniser and edge-detect history
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      key_p0 <= 2'b11;
      key_p1 <= 2'b11;
      key_p2 <= 2'b11;
    end else begin
      key_p0 <= key_raw;
      key_p1 <= key_p0;
      key_p2 <= key_p1;
    end
  end

  // -------------------------------------------------------------------------
  // Edit decode: presses, auto-repeat firing, resulting step requests
  // -------------------------------------------------------------------------
  always_comb begin
    edit     = mode & select;
    press    = key_p2 & ~key_p1;
    held     = ~key_p1;
    rep_fire = '0;
    step     = '0;
    for (int k = 0; k < 2; k++) begin
      // The timer holds the number of cycles since the press (or since the
      // last repeat step), so a repeat fires exactly REPEAT_DLY cycles after
      // the press and every REPEAT_PER cycles thereafter.
      rep_fire[k] = edit & held[k] & ~press[k] &
                    (rep_on[k] ? (rep_cnt[k] == PER_CYC)
                               : (rep_cnt[k] == DLY_CYC));
      step[k]     = edit & (press[k] | rep_fire[k]);
    end
  end

  // Repeat timers are cleared whenever the key is up or the unit is not
  // being edited, so run mode and select=0 never accumulate repeat state.
  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      rep_cnt[KEY_INC] <= '0;
      rep_cnt[KEY_DEC] <= '0;
      rep_on           <= '0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (!edit || !held[k]) begin
          rep_cnt[k] <= '0;
          rep_on[k]  <= 1'b0;
        end else if (press[k]) begin
          rep_cnt[k] <= RW'(1);
          rep_on[k]  <= 1'b0;
        end else if (rep_fire[k]) begin
          rep_cnt[k] <= RW'(1);
          rep_on[k]  <= 1'b1;
        end else begin
          rep_cnt[k] <= rep_cnt[k] + 1'b1;
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Prescaler: held at 0 in set mode, so leaving set mode restarts a full
  // CLK_HZ-cycle second before the first tick.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
    end else if (mode || presc == PRESC_LAST) begin
      presc <= '0;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  assign int_tick = ~mode & (presc == PRESC_LAST);
  assign adv      = ~mode & ((USE_EXT_TICK != 0) ? tick_in : int_tick);

  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      armed <= 1'b0;
    end else begin
      armed <= 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Count update: run-mode advance and set-mode stepping are mutually
  // exclusive because adv requires mode=0 and step requires mode=1.
  // Simultaneous inc and dec steps cancel.
  // -------------------------------------------------------------------------
  always_comb begin
    count_nxt = count;
    carry_nxt = 1'b0;
    if (armed) begin
      if (adv) begin
        count_nxt = step_up(count);
        carry_nxt = (count == CNT_MAX);
      end else if (step[KEY_INC] && !step[KEY_DEC]) begin
        count_nxt = step_up(count);
      end else if (step[KEY_DEC] && !step[KEY_INC]) begin
        count_nxt = step_down(count);
      end
    end
  end

  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      count     <= '0;
      carry_out <= 1'b0;
    end else begin
      count     <= count_nxt;
      carry_out <= carry_nxt;
    end
  end

  // -------------------------------------------------------------------------
  // BCD split for the display drivers
  // -------------------------------------------------------------------------
  assign bcd_tens = to_tens(count);
  assign bcd_ones = to_ones(count);

endmodule
